prbs_multilane_ber_monitor: RTL and testbench

//  Multi-lane PRBS bit-error-rate monitor for the receive end of the SERDES link model. It sits after grey_decode, one serial bit per lane.
//  Per lane it self-seeds from received data, verifies lock, then counts bits and errors against a free-running reference LFSR.
//  It replaces the single-lane, PRBS31-only checker. Additions: run-time polynomial select, saturating counters, lock status, windowed loss-of-lock detection.

---
 rtl/prbs_pkg.sv | 42 ++++
 rtl/prbs_lane_check.sv | 164 ++++++++++++++++
 rtl/prbs_multilane_ber_monitor.sv | 71 +++++++
 tb/tb_prbs_multilane_ber_monitor.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared types and polynomial lookup for the multi-lane PRBS BER monitor.
package prbs_pkg;

    localparam int PRBS_MAX_ORDER = 31;

    typedef enum logic [2:0] {
        PRBS7  = 3'd0,
        PRBS9  = 3'd1,
        PRBS15 = 3'd2,
        PRBS23 = 3'd3,
        PRBS31 = 3'd4
    } prbs_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEED   = 2'd1,
        VERIFY = 2'd2,
        CHECK  = 2'd3
    } lane_state_e;

    // Codes 5..7 fall back to PRBS31.
    function automatic logic [4:0] prbs_order(input logic [2:0] mode);
        case (mode)
            PRBS7:   return 5'd7;
            PRBS9:   return 5'd9;
            PRBS15:  return 5'd15;
            PRBS23:  return 5'd23;
            default: return 5'd31;
        endcase
    endfunction

    function automatic logic [4:0] prbs_tap(input logic [2:0] mode);
        case (mode)
            PRBS7:   return 5'd6;
            PRBS9:   return 5'd5;
            PRBS15:  return 5'd14;
            PRBS23:  return 5'd18;
            default: return 5'd28;
        endcase
    endfunction

endpackage

// File: rtl/prbs_lane_check.sv
// One PRBS checker lane: seed/verify/check FSM, 31-bit reference LFSR, saturating counters.
// Optional windowed loss-of-lock relock is built when PRBS_AUTO_RELOCK_EN is defined.
module prbs_lane_check
    import prbs_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
`ifdef PRBS_AUTO_RELOCK_EN
    ,
    parameter int WINDOW_BITS = 1024,
    parameter int LOSS_THRESH = 64
`endif
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic                   i_clear,
    input  logic                   i_force_seed,
    input  logic [4:0]             i_order_m1,
    input  logic [4:0]             i_tap_m1,
    input  logic                   i_data,
    input  logic                   i_valid,
    output lane_state_e            o_state,
    output logic [COUNT_WIDTH-1:0] o_bits,
    output logic [COUNT_WIDTH-1:0] o_errs,
    output logic [7:0]             o_loss
);

    lane_state_e                 r_state, w_state_nxt;
    logic [4:0]                  r_cnt, w_cnt_nxt;
    logic [PRBS_MAX_ORDER-1:0]   r_lfsr, w_lfsr_nxt;
    logic [COUNT_WIDTH-1:0]      r_bits, r_errs;
    logic                        w_pred, w_mismatch, w_count_bit, w_count_err;

`ifdef PRBS_AUTO_RELOCK_EN
    localparam int WB_W = $clog2(WINDOW_BITS + 1);
    localparam int WE_W = $clog2(LOSS_THRESH + 1);
    logic [WB_W-1:0] r_win_bits;
    logic [WE_W-1:0] r_win_errs;
    logic [7:0]      r_loss;
    logic            w_thresh_hit, w_lost;
    assign w_thresh_hit = w_mismatch && (r_win_errs == WE_W'(LOSS_THRESH - 1));
`endif

    assign w_pred     = r_lfsr[i_order_m1] ^ r_lfsr[i_tap_m1];
    assign w_mismatch = i_data ^ w_pred;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lfsr_nxt  = r_lfsr;
        w_count_bit = 1'b0;
        w_count_err = 1'b0;
`ifdef PRBS_AUTO_RELOCK_EN
        w_lost      = 1'b0;
`endif
        if (!i_en) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else if (i_force_seed) begin
            w_state_nxt = SEED;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = SEED;
                    w_cnt_nxt   = '0;
                end
                SEED: if (i_valid) begin
                    w_lfsr_nxt = {r_lfsr[PRBS_MAX_ORDER-2:0], i_data};
                    if (r_cnt == i_order_m1) begin
                        w_state_nxt = VERIFY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 5'd1;
                    end
                end
                VERIFY: if (i_valid) begin
                    w_lfsr_nxt = {r_lfsr[PRBS_MAX_ORDER-2:0], w_pred};
                    if (w_mismatch) begin
                        w_state_nxt = SEED;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == i_order_m1) begin
                        w_state_nxt = CHECK;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 5'd1;
                    end
                end
                CHECK: if (i_valid) begin
                    // Reference keeps running on its own prediction so a flipped bit counts once.
                    w_lfsr_nxt  = {r_lfsr[PRBS_MAX_ORDER-2:0], w_pred};
                    w_count_bit = 1'b1;
                    w_count_err = w_mismatch;
`ifdef PRBS_AUTO_RELOCK_EN
                    if (w_thresh_hit) begin
                        w_state_nxt = SEED;
                        w_cnt_nxt   = '0;
                        w_lost      = 1'b1;
                    end
`endif
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_lfsr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lfsr  <= w_lfsr_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bits <= '0;
            r_errs <= '0;
        end else if (i_clear) begin
            r_bits <= '0;
            r_errs <= '0;
        end else begin
            if (w_count_bit && (r_bits != '1)) r_bits <= r_bits + 1'b1;
            if (w_count_err && (r_errs != '1)) r_errs <= r_errs + 1'b1;
        end
    end

`ifdef PRBS_AUTO_RELOCK_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_win_bits <= '0;
            r_win_errs <= '0;
            r_loss     <= '0;
        end else begin
            if (i_clear || (r_state != CHECK) || w_lost) begin
                r_win_bits <= '0;
                r_win_errs <= '0;
            end else if (w_count_bit) begin
                if (r_win_bits == WB_W'(WINDOW_BITS - 1)) begin
                    r_win_bits <= '0;
                    r_win_errs <= '0;
                end else begin
                    r_win_bits <= r_win_bits + 1'b1;
                    r_win_errs <= r_win_errs + WE_W'(w_count_err);
                end
            end
            if (i_clear)                         r_loss <= '0;
            else if (w_lost && (r_loss != 8'hFF)) r_loss <= r_loss + 8'd1;
        end
    end
    assign o_loss = r_loss;
`else
    assign o_loss = '0;
`endif

    assign o_state = r_state;
    assign o_bits  = r_bits;
    assign o_errs  = r_errs;

endmodule

// File: rtl/prbs_multilane_ber_monitor.sv
// Multi-lane PRBS BER monitor top: mode register, mode-change reseed, lane array, output packing.
// Define PRBS_AUTO_RELOCK_EN to build windowed loss-of-lock detection with automatic relock.
module prbs_multilane_ber_monitor
    import prbs_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int COUNT_WIDTH = 32,
    parameter int WINDOW_BITS = 1024,
    parameter int LOSS_THRESH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         clear,
    input  logic [2:0]                   mode,
    input  logic [LANES-1:0]             data_in,
    input  logic [LANES-1:0]             data_in_valid,
    output logic [LANES-1:0]             locked,
    output logic [LANES*COUNT_WIDTH-1:0] total_bits,
    output logic [LANES*COUNT_WIDTH-1:0] total_bit_errors,
    output logic [LANES*8-1:0]           lock_loss_count
);

    logic [2:0] r_mode;
    logic       w_mode_change;
    logic [4:0] w_order_m1, w_tap_m1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_mode <= '0;
        else     r_mode <= mode;
    end

    // A change is seen the cycle it is presented, so locked drops on the following cycle.
    assign w_mode_change = en && (mode != r_mode);
    assign w_order_m1    = prbs_order(r_mode) - 5'd1;
    assign w_tap_m1      = prbs_tap(r_mode) - 5'd1;

    // Window sizing only shapes hardware in the auto-relock build; an empty window is meaningless.
    if ((WINDOW_BITS < 1) || (LOSS_THRESH < 1)) begin : g_window_cfg_degenerate
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_state_e w_state;

        prbs_lane_check #(
            .COUNT_WIDTH (COUNT_WIDTH)
`ifdef PRBS_AUTO_RELOCK_EN
            ,
            .WINDOW_BITS (WINDOW_BITS),
            .LOSS_THRESH (LOSS_THRESH)
`endif
        ) u_lane (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_en         (en),
            .i_clear      (clear),
            .i_force_seed (w_mode_change),
            .i_order_m1   (w_order_m1),
            .i_tap_m1     (w_tap_m1),
            .i_data       (data_in[g]),
            .i_valid      (data_in_valid[g]),
            .o_state      (w_state),
            .o_bits       (total_bits[g*COUNT_WIDTH +: COUNT_WIDTH]),
            .o_errs       (total_bit_errors[g*COUNT_WIDTH +: COUNT_WIDTH]),
            .o_loss       (lock_loss_count[g*8 +: 8])
        );

        assign locked[g] = (w_state == CHECK);
    end

endmodule

// File: tb/tb_prbs_multilane_ber_monitor.sv
// Directed bench for prbs_multilane_ber_monitor: a 4-lane/32-bit instance and a 1-lane/4-bit instance.
module tb_prbs_multilane_ber_monitor;

    logic        clk, rst, en, clear;
    logic [2:0]  mode;
    logic [3:0]  data_in, data_in_valid, locked;
    logic [127:0] total_bits, total_bit_errors;
    logic [31:0] lock_loss_count;

    logic        d4_en, d4_clear;
    logic [2:0]  d4_mode;
    logic [0:0]  d4_data, d4_valid, d4_locked;
    logic [3:0]  d4_bits, d4_errs;
    logic [7:0]  d4_loss;

    logic [30:0] src [4];
    logic [30:0] s4;
    int          total = 0;
    int          bad   = 0;
    logic        l1_ever_locked;
    logic        b0, b1;

    prbs_multilane_ber_monitor #(.LANES(4), .COUNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .mode(mode),
        .data_in(data_in), .data_in_valid(data_in_valid), .locked(locked),
        .total_bits(total_bits), .total_bit_errors(total_bit_errors),
        .lock_loss_count(lock_loss_count)
    );

    prbs_multilane_ber_monitor #(.LANES(1), .COUNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(d4_en), .clear(d4_clear), .mode(d4_mode),
        .data_in(d4_data), .data_in_valid(d4_valid), .locked(d4_locked),
        .total_bits(d4_bits), .total_bit_errors(d4_errs),
        .lock_loss_count(d4_loss)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bits_of(input int l);
        return total_bits[l*32 +: 32];
    endfunction

    function automatic logic [31:0] errs_of(input int l);
        return total_bit_errors[l*32 +: 32];
    endfunction

    task automatic gen_bit(input int lane, input int ord, input int tap, output logic b);
        b = src[lane][ord-1] ^ src[lane][tap-1];
        src[lane] = {src[lane][29:0], b};
    endtask

    // Sends n valid bits on one lane; every flip_period-th bit is inverted (0 = clean).
    task automatic send(input int lane, input int n, input int ord, input int tap, input int flip_period);
        logic b;
        for (int k = 1; k <= n; k++) begin
            gen_bit(lane, ord, tap, b);
            data_in[lane]       = (flip_period != 0 && (k % flip_period) == 0) ? ~b : b;
            data_in_valid[lane] = 1'b1;
            tick();
        end
        data_in_valid[lane] = 1'b0;
    endtask

    task automatic send4(input int n, input logic flip);
        logic b;
        for (int k = 0; k < n; k++) begin
            b  = s4[6] ^ s4[5];
            s4 = {s4[29:0], b};
            d4_data[0]  = flip ? ~b : b;
            d4_valid[0] = 1'b1;
            tick();
        end
        d4_valid[0] = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; clear = 1'b0; mode = 3'd4;
        data_in = '0; data_in_valid = '0;
        d4_en = 1'b1; d4_clear = 1'b0; d4_mode = 3'd0; d4_data = '0; d4_valid = '0;
        src[0] = 31'h1; src[1] = 31'h5A5; src[2] = 31'h35; src[3] = 31'h1;
        s4 = 31'h1B;
        l1_ever_locked = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_bits", 64'(|total_bits), 64'd0);
        check("rst_errs", 64'(|total_bit_errors), 64'd0);
        check("rst_loss", 64'(lock_loss_count), 64'd0);
        rst = 1'b0;
        tick();
        tick();

        // PRBS31 on lane 0 and PRBS15 on lane 1, both with mode=PRBS31.
        for (int k = 1; k <= 1000; k++) begin
            gen_bit(0, 31, 28, b0);
            gen_bit(1, 15, 14, b1);
            data_in[0] = b0;
            data_in[1] = b1;
            data_in_valid = 4'b0011;
            tick();
            if (locked[1]) l1_ever_locked = 1'b1;
            if (k == 61) check("lock_before_62", 64'(locked[0]), 64'd0);
            if (k == 62) check("lock_after_62", 64'(locked[0]), 64'd1);
        end
        data_in_valid = '0;
        check("prbs31_bits", 64'(bits_of(0)), 64'd938);
        check("prbs31_errs", 64'(errs_of(0)), 64'd0);
        check("wrong_poly_never_locks", 64'(l1_ever_locked), 64'd0);
        check("wrong_poly_bits", 64'(bits_of(1)), 64'd0);
        check("wrong_poly_errs", 64'(errs_of(1)), 64'd0);

        // Mode 4 -> 0 with a PRBS7 source.
        mode = 3'd0;
        tick();
        check("mode_change_unlock", 64'(locked[0]), 64'd0);
        src[0] = 31'h4B;
        send(0, 13, 7, 6, 0);
        check("relock_not_yet", 64'(locked[0]), 64'd0);
        send(0, 1, 7, 6, 0);
        check("relock_14", 64'(locked[0]), 64'd1);
        check("mode_change_bits_kept", 64'(bits_of(0)), 64'd938);
        check("mode_change_errs_kept", 64'(errs_of(0)), 64'd0);

        // Five isolated bit flips on a locked PRBS7 lane.
        send(0, 200, 7, 6, 40);
        check("flip5_errs", 64'(errs_of(0)), 64'd5);
        check("flip5_bits", 64'(bits_of(0)), 64'd1138);
        check("flip5_locked", 64'(locked[0]), 64'd1);

        // 64 errors within one window on lane 2.
        send(2, 14, 7, 6, 0);
        check("lane2_lock", 64'(locked[2]), 64'd1);
        send(2, 252, 7, 6, 4);
        check("win63_locked", 64'(locked[2]), 64'd1);
        check("win63_errs", 64'(errs_of(2)), 64'd63);
        send(2, 4, 7, 6, 4);
        check("win64_errs", 64'(errs_of(2)), 64'd64);
        check("win64_bits", 64'(bits_of(2)), 64'd256);
`ifdef PRBS_AUTO_RELOCK_EN
        check("win64_unlocked", 64'(locked[2]), 64'd0);
        check("win64_loss", 64'(lock_loss_count[2*8 +: 8]), 64'd1);
`else
        check("win64_still_locked", 64'(locked[2]), 64'd1);
        check("win64_loss_tied", 64'(lock_loss_count[2*8 +: 8]), 64'd0);
`endif
        send(2, 14, 7, 6, 0);
        check("lane2_locked_after", 64'(locked[2]), 64'd1);

        // Saturation and clear on the 4-bit instance.
        send4(14, 1'b0);
        check("d4_lock", 64'(d4_locked), 64'd1);
        send4(20, 1'b1);
        check("d4_errs_sat", 64'(d4_errs), 64'd15);
        check("d4_bits_sat", 64'(d4_bits), 64'd15);
        d4_clear = 1'b1;
        send4(1, 1'b1);
        d4_clear = 1'b0;
        check("d4_clear_errs", 64'(d4_errs), 64'd0);
        check("d4_clear_bits", 64'(d4_bits), 64'd0);
        check("d4_clear_keeps_lock", 64'(d4_locked), 64'd1);

        // en=0 parks lanes and holds counters; re-enable needs a full reseed.
        en = 1'b0;
        tick();
        check("en0_unlocked", 64'(locked), 64'd0);
        check("en0_bits_held", 64'(bits_of(0)), 64'd1138);
        en = 1'b1;
        tick();
        send(0, 13, 7, 6, 0);
        check("reen_not_yet", 64'(locked[0]), 64'd0);
        send(0, 1, 7, 6, 0);
        check("reen_lock", 64'(locked[0]), 64'd1);
        send(0, 10, 7, 6, 0);
        check("reen_bits", 64'(bits_of(0)), 64'd1148);

        // Asynchronous reset mid-CHECK.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_locked", 64'(locked), 64'd0);
        check("async_rst_bits", 64'(|total_bits), 64'd0);
        check("async_rst_errs", 64'(|total_bit_errors), 64'd0);
        check("async_rst_d4_errs", 64'(d4_errs), 64'd0);
        check("async_rst_d4_locked", 64'(d4_locked), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
